// File: rtl/jtag_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : jtag_scan_ctrl
// Brief  : Command-driven JTAG master: runs TAP reset, IR/DR scans and idle
//          cycles, tracks the target TAP state. Optional TDO capture is
//          enabled by defining JTAG_TDO_CAPTURE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module jtag_scan_ctrl #(
  parameter int MAX_LEN = 32
) (
  input  logic                     TCLK,
  input  logic                     TRST_N,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(MAX_LEN):0] cmd_len,
  input  logic [MAX_LEN-1:0]       cmd_data,
  output logic                     TMS,
  output logic                     TDI,
  input  logic                     TDO,
  output logic                     rsp_valid,
  output logic [MAX_LEN-1:0]       rsp_data,
  output logic [3:0]               tap_state
);

  localparam int c_lw = $clog2(MAX_LEN) + 1;
  localparam int c_cw = c_lw + 3;
  typedef logic [c_cw-1:0] cnt_t;

  localparam cnt_t c_one = cnt_t'(1);
  localparam cnt_t c_max = cnt_t'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] c_lsb = {{(MAX_LEN-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_op_rst  = 2'b00;
  localparam logic [1:0] c_op_ir   = 2'b01;
  localparam logic [1:0] c_op_dr   = 2'b10;

  localparam logic [3:0] c_tap_tlr      = 4'h0;
  localparam logic [3:0] c_tap_rti      = 4'h1;
  localparam logic [3:0] c_tap_sel_dr   = 4'h2;
  localparam logic [3:0] c_tap_cap_dr   = 4'h3;
  localparam logic [3:0] c_tap_shift_dr = 4'h4;
  localparam logic [3:0] c_tap_ex1_dr   = 4'h5;
  localparam logic [3:0] c_tap_pause_dr = 4'h6;
  localparam logic [3:0] c_tap_ex2_dr   = 4'h7;
  localparam logic [3:0] c_tap_upd_dr   = 4'h8;
  localparam logic [3:0] c_tap_sel_ir   = 4'h9;
  localparam logic [3:0] c_tap_cap_ir   = 4'hA;
  localparam logic [3:0] c_tap_shift_ir = 4'hB;
  localparam logic [3:0] c_tap_ex1_ir   = 4'hC;
  localparam logic [3:0] c_tap_pause_ir = 4'hD;
  localparam logic [3:0] c_tap_ex2_ir   = 4'hE;
  localparam logic [3:0] c_tap_upd_ir   = 4'hF;

  typedef enum logic [1:0] {
    ST_WAKE = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_tap;
  logic               r_tms;
  logic               r_tdi;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic [1:0]         r_op;
  cnt_t               r_len;
  cnt_t               r_cnt;
  cnt_t               r_total;
  logic [MAX_LEN-1:0] r_data;

  logic [3:0]         w_tap_nxt;
  logic               w_accept;
  cnt_t               w_len_ext;
  cnt_t               w_len_eff;
  logic [1:0]         w_op;
  cnt_t               w_len;
  logic [MAX_LEN-1:0] w_data;
  cnt_t               w_k;
  cnt_t               w_pre;
  cnt_t               w_shift_hi;
  logic               w_in_shift;
  logic               w_tms_nxt;
  logic               w_tdi_nxt;
  cnt_t               w_total;

  // Target TAP model, advanced by the TMS value currently on the wire.
  always_comb begin
    w_tap_nxt = r_tap;
    case (r_tap)
      c_tap_tlr:      w_tap_nxt = r_tms ? c_tap_tlr    : c_tap_rti;
      c_tap_rti:      w_tap_nxt = r_tms ? c_tap_sel_dr : c_tap_rti;
      c_tap_sel_dr:   w_tap_nxt = r_tms ? c_tap_sel_ir : c_tap_cap_dr;
      c_tap_cap_dr:   w_tap_nxt = r_tms ? c_tap_ex1_dr : c_tap_shift_dr;
      c_tap_shift_dr: w_tap_nxt = r_tms ? c_tap_ex1_dr : c_tap_shift_dr;
      c_tap_ex1_dr:   w_tap_nxt = r_tms ? c_tap_upd_dr : c_tap_pause_dr;
      c_tap_pause_dr: w_tap_nxt = r_tms ? c_tap_ex2_dr : c_tap_pause_dr;
      c_tap_ex2_dr:   w_tap_nxt = r_tms ? c_tap_upd_dr : c_tap_shift_dr;
      c_tap_upd_dr:   w_tap_nxt = r_tms ? c_tap_sel_dr : c_tap_rti;
      c_tap_sel_ir:   w_tap_nxt = r_tms ? c_tap_tlr    : c_tap_cap_ir;
      c_tap_cap_ir:   w_tap_nxt = r_tms ? c_tap_ex1_ir : c_tap_shift_ir;
      c_tap_shift_ir: w_tap_nxt = r_tms ? c_tap_ex1_ir : c_tap_shift_ir;
      c_tap_ex1_ir:   w_tap_nxt = r_tms ? c_tap_upd_ir : c_tap_pause_ir;
      c_tap_pause_ir: w_tap_nxt = r_tms ? c_tap_ex2_ir : c_tap_pause_ir;
      c_tap_ex2_ir:   w_tap_nxt = r_tms ? c_tap_upd_ir : c_tap_shift_ir;
      c_tap_upd_ir:   w_tap_nxt = r_tms ? c_tap_sel_dr : c_tap_rti;
      default:        w_tap_nxt = c_tap_tlr;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
  assign w_len_ext = {{(c_cw-c_lw){1'b0}}, cmd_len};

  always_comb begin
    if (w_len_ext == '0)
      w_len_eff = c_one;
    else if (w_len_ext > c_max)
      w_len_eff = c_max;
    else
      w_len_eff = w_len_ext;
  end

  // Cycle k of the command being set up: k=1 on acceptance, r_cnt+1 afterwards.
  assign w_op       = w_accept ? cmd_op    : r_op;
  assign w_len      = w_accept ? w_len_eff : r_len;
  assign w_data     = w_accept ? cmd_data  : r_data;
  assign w_k        = w_accept ? c_one     : (r_cnt + c_one);
  assign w_pre      = (w_op == c_op_ir) ? cnt_t'(4) : cnt_t'(3);
  assign w_shift_hi = w_pre + w_len;
  assign w_in_shift = ((w_op == c_op_ir) || (w_op == c_op_dr)) &&
                      (w_k > w_pre) && (w_k <= w_shift_hi);
  assign w_tdi_nxt  = w_in_shift & (|(w_data & (c_lsb << (w_k - w_pre - c_one))));

  always_comb begin
    w_tms_nxt = 1'b0;
    case (w_op)
      c_op_rst: w_tms_nxt = (w_k < cnt_t'(6));
      c_op_ir, c_op_dr: begin
        if (w_k <= w_pre)
          w_tms_nxt = (w_k == c_one) || ((w_op == c_op_ir) && (w_k == cnt_t'(2)));
        else if (w_k <= w_shift_hi)
          w_tms_nxt = (w_k == w_shift_hi);
        else
          w_tms_nxt = (w_k == (w_shift_hi + c_one));
      end
      default: w_tms_nxt = 1'b0;
    endcase
  end

  always_comb begin
    case (w_op)
      c_op_rst: w_total = cnt_t'(6);
      c_op_ir:  w_total = w_len + cnt_t'(6);
      c_op_dr:  w_total = w_len + cnt_t'(5);
      default:  w_total = w_len;
    endcase
  end

  always_ff @(posedge TCLK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_state     <= ST_WAKE;
      r_tap       <= c_tap_tlr;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_op        <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_total     <= '0;
      r_data      <= '0;
    end else begin
      r_tap       <= w_tap_nxt;
      r_rsp_valid <= 1'b0;
      case (r_state)
        // One TMS=0 cycle walks the target from Test_Logic_Reset to Run_Test.
        ST_WAKE: begin
          r_tms <= 1'b0;
          r_tdi <= 1'b0;
          if (!r_tms) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_tms <= 1'b0;
          r_tdi <= 1'b0;
          if (w_accept) begin
            r_state     <= ST_BUSY;
            r_cmd_ready <= 1'b0;
            r_op        <= cmd_op;
            r_len       <= w_len_eff;
            r_data      <= cmd_data;
            r_cnt       <= c_one;
            r_total     <= w_total;
            r_tms       <= w_tms_nxt;
            r_tdi       <= w_tdi_nxt;
          end
        end
        ST_BUSY: begin
          if (r_cnt == r_total) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_tms       <= 1'b0;
            r_tdi       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_one;
            r_tms <= w_tms_nxt;
            r_tdi <= w_tdi_nxt;
          end
        end
        default: begin
          r_state <= ST_WAKE;
          r_tms   <= 1'b1;
          r_tdi   <= 1'b0;
        end
      endcase
    end
  end

`ifdef JTAG_TDO_CAPTURE_EN
  logic [MAX_LEN-1:0] r_rsp_data;
  logic [MAX_LEN-1:0] w_cap_mask;
  logic               w_cap_en;

  // Shift bit i lives in command cycle pre+1+i.
  assign w_cap_mask = c_lsb << (r_cnt - ((r_op == c_op_ir) ? cnt_t'(5) : cnt_t'(4)));
  assign w_cap_en   = (r_state == ST_BUSY) &&
                      ((r_tap == c_tap_shift_dr) || (r_tap == c_tap_shift_ir));

  always_ff @(posedge TCLK or negedge TRST_N) begin
    if (!TRST_N)
      r_rsp_data <= '0;
    else if (w_accept)
      r_rsp_data <= '0;
    else if (w_cap_en)
      r_rsp_data <= (r_rsp_data & ~w_cap_mask) | ({MAX_LEN{TDO}} & w_cap_mask);
  end

  assign rsp_data = r_rsp_data;
`else
  logic w_tdo_unused;
  assign w_tdo_unused = TDO;
  assign rsp_data     = '0;
`endif

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign TMS       = r_tms;
  assign TDI       = r_tdi;
  assign tap_state = r_tap;

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_ctrl.sv
`default_nettype none
// Testbench for jtag_scan_ctrl: directed scenarios plus randomized commands
// checked against a sequence-level reference model.
`timescale 1ns/1ps
module tb_jtag_scan_ctrl;

  localparam int MAX_LEN = 32;
  localparam int LW = $clog2(MAX_LEN) + 1;

  logic               TCLK = 1'b0;
  logic               TRST_N = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [LW-1:0]      cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               TMS;
  logic               TDI;
  logic               TDO = 1'b0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic [3:0]         tap_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 TCLK = ~TCLK;

  jtag_scan_ctrl #(.MAX_LEN(MAX_LEN)) dut (
    .TCLK(TCLK), .TRST_N(TRST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tap_state(tap_state)
  );

  // IEEE 1149.1 TAP successor for TMS=0 and TMS=1, indexed by state code.
  localparam logic [3:0] NXT0 [16] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                                       4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
  localparam logic [3:0] NXT1 [16] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                                       4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};

  int                 exp_n;
  logic [63:0]        exp_tms, exp_tdi;
  logic [255:0]       exp_tap;
  logic [MAX_LEN-1:0] exp_rsp;

  int                 obs_n, obs_wait;
  logic [63:0]        obs_tms, obs_tdi, drv_tdo;
  logic [255:0]       obs_tap;
  logic               obs_busy_ready, obs_ready_end;
  logic [3:0]         obs_tap_end;
  logic [MAX_LEN-1:0] obs_rsp;

  // Expected per-cycle TMS/TDI/tap trace straight from the op definitions.
  task automatic model_cmd(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data);
    bit q[$];
    int eff, si;
    logic [3:0] st;
    eff = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
    if (op == 2'b00) begin
      for (int i = 0; i < 6; i++) q.push_back(i < 5);
    end else if (op == 2'b11) begin
      for (int i = 0; i < eff; i++) q.push_back(1'b0);
    end else begin
      q.push_back(1'b1);
      if (op == 2'b01) q.push_back(1'b1);
      q.push_back(1'b0);
      q.push_back(1'b0);
      for (int i = 0; i < eff; i++) q.push_back(i == eff - 1);
      q.push_back(1'b1);
      q.push_back(1'b0);
    end
    exp_n = q.size();
    exp_tms = '0; exp_tdi = '0; exp_tap = '0;
    st = 4'd1; si = 0;
    for (int k = 0; k < exp_n; k++) begin
      exp_tms[k] = q[k];
      exp_tap[4*k +: 4] = st;
      if (st == 4'd4 || st == 4'd11) begin
        exp_tdi[k] = data[si];
        si++;
      end
      st = q[k] ? NXT1[st] : NXT0[st];
    end
  endtask

  task automatic model_rsp();
    int si;
    si = 0;
    exp_rsp = '0;
    for (int k = 0; k < exp_n; k++) begin
      if (exp_tap[4*k +: 4] == 4'd4 || exp_tap[4*k +: 4] == 4'd11) begin
`ifdef JTAG_TDO_CAPTURE_EN
        exp_rsp[si] = drv_tdo[k];
`endif
        si++;
      end
    end
  endtask

  // Drives one command and records the trace; mode 0: TDO=TDI, 1: TDO=1, else random.
  task automatic exec_cmd(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data,
                          input int mode, input bit hold);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge TCLK);
      w++;
    end
    obs_wait = w;
    cmd_op = op; cmd_len = LW'(len); cmd_data = data; cmd_valid = 1'b1;
    obs_n = -1; obs_tms = '0; obs_tdi = '0; obs_tap = '0; drv_tdo = '0;
    obs_busy_ready = 1'b0; obs_ready_end = 1'b0; obs_tap_end = 4'hx; obs_rsp = 'x;
    for (int k = 0; k < 64; k++) begin
      @(negedge TCLK);
      if (!hold) cmd_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        obs_n = k;
        obs_rsp = rsp_data;
        obs_ready_end = cmd_ready;
        obs_tap_end = tap_state;
        break;
      end
      obs_tms[k] = TMS;
      obs_tdi[k] = TDI;
      obs_tap[4*k +: 4] = tap_state;
      obs_busy_ready = obs_busy_ready | cmd_ready;
      case (mode)
        0:       TDO = TDI;
        1:       TDO = 1'b1;
        default: TDO = 1'($urandom_range(0, 1));
      endcase
      drv_tdo[k] = TDO;
    end
    cmd_valid = 1'b0;
    TDO = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge TCLK);
    n_cmp++;
    if ({tap_state, TMS, TDI, cmd_ready, rsp_valid} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected %b", {tap_state, TMS, TDI, cmd_ready, rsp_valid}, 8'b0000_1000);
    end
    n_cmp++;
    if (rsp_data !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
    end
    TRST_N = 1'b1;
    @(negedge TCLK);
    n_cmp++;
    if ({TMS, tap_state, cmd_ready} !== {1'b0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL wake_cycle: got %b expected %b", {TMS, tap_state, cmd_ready}, 6'b000000);
    end
    @(negedge TCLK);
    n_cmp++;
    if ({tap_state, cmd_ready} !== {4'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL wake_ready: got %b expected %b", {tap_state, cmd_ready}, 5'b00011);
    end
  endtask

  task automatic test_tap_reset();
    model_cmd(2'b00, 0, '0);
    exec_cmd(2'b00, 0, '0, 0, 1'b0);
    n_cmp++;
    if (obs_tms[5:0] !== 6'b011111 || obs_n !== 6) begin
      n_bad++;
      $display("FAIL tapreset_tms: got %b/%0d expected 011111/6", obs_tms[5:0], obs_n);
    end
    n_cmp++;
    if (obs_tap !== exp_tap) begin
      n_bad++;
      $display("FAIL tapreset_trace: got %h expected %h", obs_tap, exp_tap);
    end
    n_cmp++;
    if (obs_tap_end !== 4'd1 || obs_ready_end !== 1'b1) begin
      n_bad++;
      $display("FAIL tapreset_end: got %h/%b expected 1/1", obs_tap_end, obs_ready_end);
    end
  endtask

  task automatic test_dr_scan();
    model_cmd(2'b10, 8, 32'hA5);
    exec_cmd(2'b10, 8, 32'hA5, 0, 1'b0);
    model_rsp();
    n_cmp++;
    if (obs_n !== 13) begin
      n_bad++;
      $display("FAIL dr_cycles: got %0d expected 13", obs_n);
    end
    n_cmp++;
    if (obs_tdi[10:3] !== 8'hA5 || obs_tdi !== exp_tdi) begin
      n_bad++;
      $display("FAIL dr_tdi: got %h expected %h", obs_tdi, exp_tdi);
    end
    n_cmp++;
    if (obs_tms !== exp_tms) begin
      n_bad++;
      $display("FAIL dr_tms: got %h expected %h", obs_tms, exp_tms);
    end
    n_cmp++;
    if (obs_rsp !== exp_rsp) begin
      n_bad++;
      $display("FAIL dr_rsp: got %h expected %h", obs_rsp, exp_rsp);
    end
  endtask

  task automatic test_ir_scan();
    int shifts;
    model_cmd(2'b01, 4, 32'h3);
    exec_cmd(2'b01, 4, 32'h3, 1, 1'b0);
    model_rsp();
    shifts = 0;
    for (int k = 0; k < 64; k++) if (obs_tap[4*k +: 4] == 4'hB) shifts++;
    n_cmp++;
    if (obs_tap !== exp_tap || obs_tap[11:8] !== 4'h9 || shifts !== 4) begin
      n_bad++;
      $display("FAIL ir_trace: got %h expected %h", obs_tap, exp_tap);
    end
    n_cmp++;
    if (obs_n !== 10) begin
      n_bad++;
      $display("FAIL ir_cycles: got %0d expected 10", obs_n);
    end
    n_cmp++;
    if (obs_rsp !== exp_rsp) begin
      n_bad++;
      $display("FAIL ir_rsp: got %h expected %h", obs_rsp, exp_rsp);
    end
  endtask

  task automatic test_boundaries();
    logic [MAX_LEN-1:0] d;
    model_cmd(2'b10, 0, 32'h1);
    exec_cmd(2'b10, 0, 32'h1, 0, 1'b0);
    n_cmp++;
    if (obs_n !== 6 || obs_tms !== exp_tms || obs_tdi !== exp_tdi) begin
      n_bad++;
      $display("FAIL len0: got %0d/%h expected 6/%h", obs_n, obs_tms, exp_tms);
    end
    d = $urandom;
    model_cmd(2'b01, 40, d);
    exec_cmd(2'b01, 40, d, 0, 1'b0);
    model_rsp();
    n_cmp++;
    if (obs_n !== 38 || obs_tdi !== exp_tdi) begin
      n_bad++;
      $display("FAIL len40_clamp: got %0d/%h expected 38/%h", obs_n, obs_tdi, exp_tdi);
    end
    n_cmp++;
    if (obs_rsp !== exp_rsp) begin
      n_bad++;
      $display("FAIL len40_rsp: got %h expected %h", obs_rsp, exp_rsp);
    end
    model_cmd(2'b10, 5, 32'h15);
    exec_cmd(2'b10, 5, 32'h15, 2, 1'b1);
    n_cmp++;
    if (obs_n !== exp_n || obs_tms !== exp_tms || obs_busy_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL held_valid: got %0d/%h/%b expected %0d/%h/0", obs_n, obs_tms, obs_busy_ready, exp_n, exp_tms);
    end
    @(negedge TCLK);
    n_cmp++;
    if ({TMS, cmd_ready, rsp_valid, tap_state} !== {1'b0, 1'b1, 1'b0, 4'd1}) begin
      n_bad++;
      $display("FAIL held_no_reaccept: got %b expected %b", {TMS, cmd_ready, rsp_valid, tap_state}, 7'b0100001);
    end
  endtask

  task automatic test_trst_mid();
    int w;
    logic seen;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge TCLK);
      w++;
    end
    cmd_op = 2'b10; cmd_len = LW'(8); cmd_data = '1; cmd_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge TCLK);
      cmd_valid = 1'b0;
    end
    n_cmp++;
    if (tap_state !== 4'd4) begin
      n_bad++;
      $display("FAIL trst_pre_shift: got %h expected 4", tap_state);
    end
    TRST_N = 1'b0;
    #1;
    n_cmp++;
    if ({TMS, tap_state, cmd_ready, rsp_valid} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL trst_abort: got %b expected %b", {TMS, tap_state, cmd_ready, rsp_valid}, 7'b1000000);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge TCLK);
      seen = seen | rsp_valid;
    end
    TRST_N = 1'b1;
    repeat (3) begin
      @(negedge TCLK);
      seen = seen | rsp_valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL trst_no_rsp: got %b expected 0", seen);
    end
    n_cmp++;
    if ({cmd_ready, tap_state} !== {1'b1, 4'd1}) begin
      n_bad++;
      $display("FAIL trst_recover: got %b expected 10001", {cmd_ready, tap_state});
    end
  endtask

  task automatic test_back_to_back();
    logic [MAX_LEN-1:0] d;
    d = $urandom;
    model_cmd(2'b10, 6, d);
    exec_cmd(2'b10, 6, d, 2, 1'b0);
    n_cmp++;
    if (obs_n !== exp_n || obs_tdi !== exp_tdi) begin
      n_bad++;
      $display("FAIL b2b_first: got %0d/%h expected %0d/%h", obs_n, obs_tdi, exp_n, exp_tdi);
    end
    model_cmd(2'b11, 3, '0);
    exec_cmd(2'b11, 3, '0, 0, 1'b0);
    n_cmp++;
    if (obs_wait !== 0) begin
      n_bad++;
      $display("FAIL b2b_accept: got wait %0d expected 0", obs_wait);
    end
    n_cmp++;
    if (obs_n !== 3 || obs_tms !== 64'd0 || obs_tap[11:0] !== 12'h111) begin
      n_bad++;
      $display("FAIL b2b_idle: got %0d/%h/%h expected 3/0/111", obs_n, obs_tms, obs_tap[11:0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    int len;
    logic [MAX_LEN-1:0] d;
    for (int t = 0; t < 24; t++) begin
      op = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 40);
      d = $urandom;
      model_cmd(op, len, d);
      exec_cmd(op, len, d, 2, 1'b0);
      model_rsp();
      n_cmp++;
      if (obs_n !== exp_n || obs_tms !== exp_tms) begin
        n_bad++;
        $display("FAIL rnd_tms[%0d] op%0d len%0d: got %0d/%h expected %0d/%h", t, op, len, obs_n, obs_tms, exp_n, exp_tms);
      end
      n_cmp++;
      if (obs_tdi !== exp_tdi || obs_tap !== exp_tap) begin
        n_bad++;
        $display("FAIL rnd_trace[%0d]: got %h/%h expected %h/%h", t, obs_tdi, obs_tap, exp_tdi, exp_tap);
      end
      n_cmp++;
      if (obs_rsp !== exp_rsp) begin
        n_bad++;
        $display("FAIL rnd_rsp[%0d]: got %h expected %h", t, obs_rsp, exp_rsp);
      end
      n_cmp++;
      if ({obs_busy_ready, obs_ready_end, obs_tap_end} !== {1'b0, 1'b1, 4'd1}) begin
        n_bad++;
        $display("FAIL rnd_handshake[%0d]: got %b expected 010001", t, {obs_busy_ready, obs_ready_end, obs_tap_end});
      end
    end
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_dr_scan();
    test_ir_scan();
    test_boundaries();
    test_trst_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
